rs_multi_issue: RTL and testbench

Parametrised, fully synchronous reservation station for the superscalar core. It sits between the decode/rename stage and the execution units. It accepts one renamed instruction per cycle and holds it until both source operands are available, capturing results from NCDB writeback (CDB) ports. It issues up to two ready instructions per cycle under a valid/ready handshake, and supports a single-cycle pipeline flush.

---
 rtl/rs_multi_issue_if.sv | 53 +++++
 rtl/rs_multi_issue.sv | 167 ++++++++++++++++
 tb/tb_rs_multi_issue.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_multi_issue_if.sv
// Dispatch, CDB broadcast, dual issue and status signals of the reservation station.
// The station is the slave; the surrounding pipeline (or a bench) is the master.
interface rs_multi_issue_if #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int TW    = 4,
  parameter int PW    = 80,
  parameter int NCDB  = 2
);
  localparam int OW = $clog2(DEPTH + 1);

  logic               flush;
  logic               disp_valid;
  logic               disp_ready;
  logic [TW-1:0]      disp_tag;
  logic [DW-1:0]      disp_src1;
  logic [DW-1:0]      disp_src2;
  logic               disp_src1_rdy;
  logic               disp_src2_rdy;
  logic [PW-1:0]      disp_payload;
  logic [NCDB-1:0]    cdb_valid;
  logic [NCDB*TW-1:0] cdb_tag;
  logic [NCDB*DW-1:0] cdb_data;
  logic               iss0_valid;
  logic               iss0_ready;
  logic               iss1_valid;
  logic               iss1_ready;
  logic [DW-1:0]      iss0_src1;
  logic [DW-1:0]      iss0_src2;
  logic [DW-1:0]      iss1_src1;
  logic [DW-1:0]      iss1_src2;
  logic [TW-1:0]      iss0_tag;
  logic [TW-1:0]      iss1_tag;
  logic [PW-1:0]      iss0_payload;
  logic [PW-1:0]      iss1_payload;
  logic [OW-1:0]      occupancy;
  logic               full;
  logic               empty;

  modport master (
    output flush, disp_valid, disp_tag, disp_src1, disp_src2, disp_src1_rdy, disp_src2_rdy,
    output disp_payload, cdb_valid, cdb_tag, cdb_data, iss0_ready, iss1_ready,
    input  disp_ready, iss0_valid, iss1_valid, iss0_src1, iss0_src2, iss1_src1, iss1_src2,
    input  iss0_tag, iss1_tag, iss0_payload, iss1_payload, occupancy, full, empty
  );

  modport slave (
    input  flush, disp_valid, disp_tag, disp_src1, disp_src2, disp_src1_rdy, disp_src2_rdy,
    input  disp_payload, cdb_valid, cdb_tag, cdb_data, iss0_ready, iss1_ready,
    output disp_ready, iss0_valid, iss1_valid, iss0_src1, iss0_src2, iss1_src1, iss1_src2,
    output iss0_tag, iss1_tag, iss0_payload, iss1_payload, occupancy, full, empty
  );
endinterface

// File: rtl/rs_multi_issue.sv
// Reservation station: one dispatch per cycle, CDB wakeup on NCDB ports,
// up to two oldest-index ready entries issued per cycle, single-cycle flush.
module rs_multi_issue #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int TW    = 4,
  parameter int PW    = 80,
  parameter int NCDB  = 2
) (
  input logic             CLK,
  input logic             reset,
  rs_multi_issue_if.slave rs
);
  localparam int IW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_s1_rdy;
  logic [DEPTH-1:0] r_s2_rdy;
  logic [DW-1:0]    r_s1      [DEPTH];
  logic [DW-1:0]    r_s2      [DEPTH];
  logic [TW-1:0]    r_tag     [DEPTH];
  logic [PW-1:0]    r_payload [DEPTH];
  logic [OW-1:0]    r_occ;

  // Returns {hit, data}; scanning downwards lets the lowest matching port win.
  function automatic logic [DW:0] f_cdb_match(input logic [TW-1:0]      tag,
                                               input logic [NCDB-1:0]    vld,
                                               input logic [NCDB*TW-1:0] tags,
                                               input logic [NCDB*DW-1:0] data);
    logic [DW:0] res;
    res = '0;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (vld[k] && tags[k*TW +: TW] == tag) res = {1'b1, data[k*DW +: DW]};
    end
    return res;
  endfunction

  logic [DW:0] w_s1_wake [DEPTH];
  logic [DW:0] w_s2_wake [DEPTH];
  logic [DW:0] w_d1_wake;
  logic [DW:0] w_d2_wake;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
    assign w_s1_wake[gi] = f_cdb_match(r_s1[gi][TW-1:0], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
    assign w_s2_wake[gi] = f_cdb_match(r_s2[gi][TW-1:0], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
  end
  assign w_d1_wake = f_cdb_match(rs.disp_src1[TW-1:0], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
  assign w_d2_wake = f_cdb_match(rs.disp_src2[TW-1:0], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);

  logic             w_free_found;
  logic [IW-1:0]    w_free_idx;
  logic [DEPTH-1:0] w_cand;
  logic             w_sel0_found;
  logic             w_sel1_found;
  logic [IW-1:0]    w_sel0_idx;
  logic [IW-1:0]    w_sel1_idx;

  assign w_cand = r_valid & r_s1_rdy & r_s2_rdy;

  // Free slot and both selections come only from registered state.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_sel0_found = 1'b0;
    w_sel0_idx   = '0;
    w_sel1_found = 1'b0;
    w_sel1_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
      if (w_cand[i]) begin
        if (!w_sel0_found) begin
          w_sel0_found = 1'b1;
          w_sel0_idx   = IW'(i);
        end else if (!w_sel1_found) begin
          w_sel1_found = 1'b1;
          w_sel1_idx   = IW'(i);
        end
      end
    end
  end

  logic             w_block;
  logic             w_disp_ready;
  logic             w_iss0_valid;
  logic             w_iss1_valid;
  logic             w_disp_fire;
  logic             w_iss0_fire;
  logic             w_iss1_fire;
  logic [DEPTH-1:0] w_iss_clr;
  logic [OW-1:0]    w_occ_next;

  assign w_block      = reset | rs.flush;
  assign w_disp_ready = w_free_found & ~w_block;
  assign w_iss0_valid = w_sel0_found & ~w_block;
  assign w_iss1_valid = w_sel1_found & ~w_block;
  assign w_disp_fire  = rs.disp_valid & w_disp_ready;
  assign w_iss0_fire  = w_iss0_valid & rs.iss0_ready;
  assign w_iss1_fire  = w_iss1_valid & rs.iss1_ready;
  assign w_occ_next   = r_occ + OW'(w_disp_fire) - OW'(w_iss0_fire) - OW'(w_iss1_fire);

  always_comb begin
    w_iss_clr = '0;
    if (w_iss0_fire) w_iss_clr[w_sel0_idx] = 1'b1;
    if (w_iss1_fire) w_iss_clr[w_sel1_idx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_valid  <= '0;
      r_s1_rdy <= '0;
      r_s2_rdy <= '0;
      r_occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_s1[i]      <= '0;
        r_s2[i]      <= '0;
        r_tag[i]     <= '0;
        r_payload[i] <= '0;
      end
    end else if (rs.flush) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_occ <= w_occ_next;
      for (int i = 0; i < DEPTH; i++) begin
        // The free slot was invalid at cycle start, so it can never be an issuing entry.
        if (w_disp_fire && w_free_idx == IW'(i)) begin
          r_valid[i]   <= 1'b1;
          r_tag[i]     <= rs.disp_tag;
          r_payload[i] <= rs.disp_payload;
          r_s1_rdy[i]  <= rs.disp_src1_rdy | w_d1_wake[DW];
          r_s2_rdy[i]  <= rs.disp_src2_rdy | w_d2_wake[DW];
          r_s1[i]      <= (!rs.disp_src1_rdy && w_d1_wake[DW]) ? w_d1_wake[DW-1:0] : rs.disp_src1;
          r_s2[i]      <= (!rs.disp_src2_rdy && w_d2_wake[DW]) ? w_d2_wake[DW-1:0] : rs.disp_src2;
        end else if (r_valid[i]) begin
          if (w_iss_clr[i]) r_valid[i] <= 1'b0;
          if (!r_s1_rdy[i] && w_s1_wake[i][DW]) begin
            r_s1_rdy[i] <= 1'b1;
            r_s1[i]     <= w_s1_wake[i][DW-1:0];
          end
          if (!r_s2_rdy[i] && w_s2_wake[i][DW]) begin
            r_s2_rdy[i] <= 1'b1;
            r_s2[i]     <= w_s2_wake[i][DW-1:0];
          end
        end
      end
    end
  end

  assign rs.disp_ready   = w_disp_ready;
  assign rs.iss0_valid   = w_iss0_valid;
  assign rs.iss1_valid   = w_iss1_valid;
  assign rs.iss0_src1    = w_iss0_valid ? r_s1[w_sel0_idx] : '0;
  assign rs.iss0_src2    = w_iss0_valid ? r_s2[w_sel0_idx] : '0;
  assign rs.iss0_tag     = w_iss0_valid ? r_tag[w_sel0_idx] : '0;
  assign rs.iss0_payload = w_iss0_valid ? r_payload[w_sel0_idx] : '0;
  assign rs.iss1_src1    = w_iss1_valid ? r_s1[w_sel1_idx] : '0;
  assign rs.iss1_src2    = w_iss1_valid ? r_s2[w_sel1_idx] : '0;
  assign rs.iss1_tag     = w_iss1_valid ? r_tag[w_sel1_idx] : '0;
  assign rs.iss1_payload = w_iss1_valid ? r_payload[w_sel1_idx] : '0;
  assign rs.occupancy    = r_occ;
  assign rs.full         = (r_occ == OW'(DEPTH));
  assign rs.empty        = (r_occ == '0);
endmodule

// File: tb/tb_rs_multi_issue.sv
// Directed bench for rs_multi_issue (DEPTH=4): a scoreboard queue holds expected
// issues, a negedge monitor pops and compares every accepted issue.
module tb_rs_multi_issue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int PW    = 80;
  localparam int NCDB  = 2;

  typedef struct packed {
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    logic [TW-1:0] tag;
    logic [PW-1:0] pl;
  } exp_t;

  logic CLK = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  rs_multi_issue_if #(.DEPTH(DEPTH), .DW(DW), .TW(TW), .PW(PW), .NCDB(NCDB)) bus ();

  rs_multi_issue #(.DEPTH(DEPTH), .DW(DW), .TW(TW), .PW(PW), .NCDB(NCDB)) dut (
    .CLK   (CLK),
    .reset (reset),
    .rs    (bus)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic score(input int port, input exp_t got);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL issue%0d unexpected: got tag %0h src1 %0h src2 %0h, expected no issue",
               port, got.tag, got.s1, got.s2);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL issue%0d: got tag %0h src1 %0h src2 %0h pl %0h, expected tag %0h src1 %0h src2 %0h pl %0h",
                 port, got.tag, got.s1, got.s2, got.pl, e.tag, e.s1, e.s2, e.pl);
      end else begin
        $display("[TB] issue%0d tag %0h src1 %0h src2 %0h", port, got.tag, got.s1, got.s2);
      end
    end
  endtask

  // Port 0 is always the lower-index (older-queued) entry, so pop it first.
  always @(negedge CLK) begin
    if (bus.iss0_valid && bus.iss0_ready)
      score(0, {bus.iss0_src1, bus.iss0_src2, bus.iss0_tag, bus.iss0_payload});
    if (bus.iss1_valid && bus.iss1_ready)
      score(1, {bus.iss1_src1, bus.iss1_src2, bus.iss1_tag, bus.iss1_payload});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic push(input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                      input logic [TW-1:0] tag, input logic [PW-1:0] pl);
    exp_t e;
    e.s1 = s1; e.s2 = s2; e.tag = tag; e.pl = pl;
    exp_q.push_back(e);
  endtask

  task automatic drive_disp(input logic [TW-1:0] tag, input logic [DW-1:0] s1, input logic r1,
                            input logic [DW-1:0] s2, input logic r2, input logic [PW-1:0] pl);
    bus.disp_valid    = 1'b1;
    bus.disp_tag      = tag;
    bus.disp_src1     = s1;
    bus.disp_src1_rdy = r1;
    bus.disp_src2     = s2;
    bus.disp_src2_rdy = r2;
    bus.disp_payload  = pl;
  endtask

  task automatic disp(input logic [TW-1:0] tag, input logic [DW-1:0] s1, input logic r1,
                      input logic [DW-1:0] s2, input logic r2, input logic [PW-1:0] pl);
    drive_disp(tag, s1, r1, s2, r2, pl);
    tick();
    bus.disp_valid = 1'b0;
  endtask

  task automatic set_cdb(input int k, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    bus.cdb_valid[k]         = 1'b1;
    bus.cdb_tag[k*TW +: TW]  = tag;
    bus.cdb_data[k*DW +: DW] = data;
  endtask

  task automatic clr_cdb();
    bus.cdb_valid = '0;
    bus.cdb_tag   = '0;
    bus.cdb_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_tag = '0; bus.disp_src1 = '0; bus.disp_src2 = '0;
    bus.disp_src1_rdy = 1'b0; bus.disp_src2_rdy = 1'b0; bus.disp_payload = '0;
    bus.iss0_ready = 1'b0; bus.iss1_ready = 1'b0;
    clr_cdb();

    // Reset state
    at_neg();
    check("rst disp_ready", bus.disp_ready, 0);
    check("rst iss0_valid", bus.iss0_valid, 0);
    check("rst iss1_valid", bus.iss1_valid, 0);
    check("rst occupancy", bus.occupancy, 0);
    check("rst empty", bus.empty, 1);
    check("rst full", bus.full, 0);
    check("rst iss0_src1", bus.iss0_src1, 0);
    tick();
    reset = 1'b0;
    at_neg();
    check("post-rst disp_ready", bus.disp_ready, 1);

    // Basic issue
    tick();
    push(32'd5, 32'd7, 4'd3, 80'h1003);
    disp(4'd3, 32'd5, 1'b1, 32'd7, 1'b1, 80'h1003);
    bus.iss0_ready = 1'b1;
    at_neg();
    check("basic iss0_valid", bus.iss0_valid, 1);
    check("basic iss1_valid", bus.iss1_valid, 0);
    check("basic iss0_tag", bus.iss0_tag, 3);
    check("basic occupancy", bus.occupancy, 1);
    tick();
    bus.iss0_ready = 1'b0;
    at_neg();
    check("basic occ after", bus.occupancy, 0);
    check("basic empty", bus.empty, 1);
    check("idle iss0_src1", bus.iss0_src1, 0);
    check("idle iss0_payload", bus.iss0_payload, 0);

    // Wakeup across ports; lowest port wins, ready sources are kept
    tick();
    push(32'hAA, 32'hBB, 4'd1, 80'h2001);
    disp(4'd1, 32'd9, 1'b0, 32'd10, 1'b0, 80'h2001);
    set_cdb(0, 4'd9, 32'hAA);
    set_cdb(1, 4'd9, 32'hCC);
    at_neg();
    check("wake pre iss0_valid", bus.iss0_valid, 0);
    tick();
    set_cdb(0, 4'd9, 32'h55);
    set_cdb(1, 4'd10, 32'hBB);
    at_neg();
    check("wake half iss0_valid", bus.iss0_valid, 0);
    tick();
    clr_cdb();
    bus.iss0_ready = 1'b1;
    at_neg();
    check("wake iss0_valid", bus.iss0_valid, 1);
    tick();
    bus.iss0_ready = 1'b0;

    // Dispatch capture from port 1 while port 0 carries an unrelated tag
    set_cdb(0, 4'd5, 32'h999);
    set_cdb(1, 4'd6, 32'h1234);
    push(32'h1234, 32'h77, 4'd2, 80'h3002);
    disp(4'd2, 32'd6, 1'b0, 32'h77, 1'b1, 80'h3002);
    clr_cdb();
    bus.iss0_ready = 1'b1;
    at_neg();
    check("capture iss0_valid", bus.iss0_valid, 1);
    tick();
    bus.iss0_ready = 1'b0;
    at_neg();
    check("capture empty", bus.empty, 1);

    // Dual issue and backpressure
    tick();
    for (int i = 0; i < 4; i++)
      disp(TW'(4 + i), 32'h40 + i, 1'b1, 32'h50 + i, 1'b1, 80'h4000 + i);
    at_neg();
    check("dual full", bus.full, 1);
    check("dual disp_ready", bus.disp_ready, 0);
    check("dual occupancy", bus.occupancy, 4);
    check("dual iss0_tag", bus.iss0_tag, 4);
    check("dual iss1_valid", bus.iss1_valid, 1);
    check("dual iss1_tag", bus.iss1_tag, 5);
    tick();
    push(32'h40, 32'h50, 4'd4, 80'h4000);
    bus.iss0_ready = 1'b1;
    at_neg();
    tick();
    bus.iss0_ready = 1'b0;
    at_neg();
    check("bp occupancy", bus.occupancy, 3);
    check("bp iss0_tag", bus.iss0_tag, 5);
    check("bp iss1_tag", bus.iss1_tag, 6);
    check("bp disp_ready", bus.disp_ready, 1);
    tick();
    push(32'h41, 32'h51, 4'd5, 80'h4001);
    push(32'h42, 32'h52, 4'd6, 80'h4002);
    push(32'h43, 32'h53, 4'd7, 80'h4003);
    bus.iss0_ready = 1'b1;
    bus.iss1_ready = 1'b1;
    at_neg();
    tick();
    at_neg();
    tick();
    bus.iss0_ready = 1'b0;
    bus.iss1_ready = 1'b0;
    at_neg();
    check("dual drained empty", bus.empty, 1);

    // Full and refill into the freed lowest index
    tick();
    for (int i = 0; i < 4; i++)
      disp(TW'(8 + i), 32'd12 + i, 1'b0, 32'h50 + i, 1'b1, 80'h5008 + i);
    at_neg();
    check("fill full", bus.full, 1);
    check("fill disp_ready", bus.disp_ready, 0);
    check("fill iss0_valid", bus.iss0_valid, 0);
    tick();
    drive_disp(4'd0, 32'h66, 1'b1, 32'h67, 1'b1, 80'h5555);
    set_cdb(0, 4'd14, 32'hE0);
    at_neg();
    check("held disp_ready", bus.disp_ready, 0);
    tick();
    clr_cdb();
    push(32'hE0, 32'h52, 4'd10, 80'h500A);
    bus.iss0_ready = 1'b1;
    at_neg();
    check("refill iss0_tag", bus.iss0_tag, 10);
    check("refill still full", bus.disp_ready, 0);
    tick();
    bus.iss0_ready = 1'b0;
    at_neg();
    check("refill disp_ready", bus.disp_ready, 1);
    check("refill occupancy", bus.occupancy, 3);
    tick();
    bus.disp_valid = 1'b0;
    at_neg();
    check("refill occ 4", bus.occupancy, 4);
    check("refill iss0_tag new", bus.iss0_tag, 0);
    tick();
    set_cdb(0, 4'd12, 32'hC0);
    tick();
    clr_cdb();
    at_neg();
    check("slot iss0_tag", bus.iss0_tag, 8);
    check("slot iss1_tag", bus.iss1_tag, 0);
    tick();
    push(32'hC0, 32'h50, 4'd8, 80'h5008);
    push(32'h66, 32'h67, 4'd0, 80'h5555);
    bus.iss0_ready = 1'b1;
    bus.iss1_ready = 1'b1;
    at_neg();
    tick();
    bus.iss0_ready = 1'b0;
    bus.iss1_ready = 1'b0;
    at_neg();
    check("refill occ 2", bus.occupancy, 2);

    // Flush with simultaneous dispatch, CDB and ready
    tick();
    disp(4'd3, 32'd1, 1'b1, 32'd2, 1'b1, 80'h6003);
    at_neg();
    check("pre-flush occupancy", bus.occupancy, 3);
    tick();
    bus.flush = 1'b1;
    drive_disp(4'd5, 32'd3, 1'b1, 32'd4, 1'b1, 80'h6005);
    set_cdb(0, 4'd13, 32'hD0);
    bus.iss0_ready = 1'b1;
    bus.iss1_ready = 1'b1;
    at_neg();
    check("flush iss0_valid", bus.iss0_valid, 0);
    check("flush disp_ready", bus.disp_ready, 0);
    tick();
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    set_cdb(0, 4'd15, 32'hF0);
    set_cdb(1, 4'd13, 32'hD1);
    at_neg();
    check("flush occupancy", bus.occupancy, 0);
    check("flush empty", bus.empty, 1);
    check("flush iss0_valid after", bus.iss0_valid, 0);
    check("flush iss1_valid after", bus.iss1_valid, 0);
    check("flush disp_ready after", bus.disp_ready, 1);
    repeat (3) tick();
    clr_cdb();
    bus.iss0_ready = 1'b0;
    bus.iss1_ready = 1'b0;

    // Reset mid-operation, same required response
    disp(4'd1, 32'h11, 1'b1, 32'h12, 1'b1, 80'h7001);
    disp(4'd2, 32'd13, 1'b0, 32'd1, 1'b1, 80'h7002);
    disp(4'd4, 32'd15, 1'b0, 32'd2, 1'b1, 80'h7004);
    at_neg();
    check("pre-rst occupancy", bus.occupancy, 3);
    tick();
    reset = 1'b1;
    drive_disp(4'd6, 32'd3, 1'b1, 32'd4, 1'b1, 80'h7006);
    set_cdb(0, 4'd13, 32'hD0);
    bus.iss0_ready = 1'b1;
    bus.iss1_ready = 1'b1;
    at_neg();
    check("mid-rst disp_ready", bus.disp_ready, 0);
    check("mid-rst iss0_valid", bus.iss0_valid, 0);
    tick();
    reset = 1'b0;
    bus.disp_valid = 1'b0;
    set_cdb(0, 4'd15, 32'hF0);
    set_cdb(1, 4'd13, 32'hD1);
    at_neg();
    check("rst2 occupancy", bus.occupancy, 0);
    check("rst2 empty", bus.empty, 1);
    check("rst2 full", bus.full, 0);
    check("rst2 iss0_valid", bus.iss0_valid, 0);
    check("rst2 iss1_valid", bus.iss1_valid, 0);
    check("rst2 iss0_src1", bus.iss0_src1, 0);
    check("rst2 disp_ready", bus.disp_ready, 1);
    repeat (3) tick();
    clr_cdb();
    bus.iss0_ready = 1'b0;
    bus.iss1_ready = 1'b0;
    at_neg();
    check("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
